tow_cpu_player: RTL and testbench

Automated opponent for the tug-of-war game. It drives a push-button line into `top` (wired to `pbr` or `pbl`) with the same press/clear pattern a human player produces:
- wait for the light;
- wait a pseudo-random reaction delay;
- hold the button a fixed number of cycles;
- wait for the referee clear before re-arming.

It sits beside `top` on the board and gives single-player mode plus a self-running demo.

---
 rtl/tow_pkg.sv | 35 +++
 rtl/tow_lfsr8.sv | 22 ++
 rtl/tow_cpu_player.sv | 113 +++++++++++
 tb/tb_tow_cpu_player.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war automated opponent.
// Holds the FSM state encoding, reaction base delays and LFSR taps.
package tow_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        REACT,
        PRESS,
        WAIT_CLR
    } state_t;

    localparam logic [4:0] BASE_L0 = 5'd12;
    localparam logic [4:0] BASE_L1 = 5'd8;
    localparam logic [4:0] BASE_L2 = 5'd4;
    localparam logic [4:0] BASE_L3 = 5'd1;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting toward the MSB
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [4:0] react_delay(
        input logic [1:0] level,
        input logic [2:0] rnd
    );
        logic [4:0] base;
        unique case (level)
            2'd0: base = BASE_L0;
            2'd1: base = BASE_L1;
            2'd2: base = BASE_L2;
            2'd3: base = BASE_L3;
        endcase
        return base + {2'b00, rnd};
    endfunction

endpackage

// File: rtl/tow_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; reusable for any pseudo-random timing.
// Shifts every cycle out of reset and reloads the seed on reset.
module tow_lfsr8
    import tow_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5,
    parameter logic [7:0] TAPS = LFSR_TAPS
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & TAPS)};
        end
    end

endmodule

// File: rtl/tow_cpu_player.sv
// Automated tug-of-war opponent: waits for the light, reacts after a
// pseudo-random delay, holds the button, then waits for the referee clear.
module tow_cpu_player
    import tow_pkg::*;
#(
    parameter int         HOLD = 2,
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       leds_on,
    input  logic       clr,
    input  logic [1:0] level,
    output logic       pb,
    output logic       busy,
    output logic [7:0] presses
);

    localparam logic [3:0] HOLD_LD = 4'(HOLD);

    state_t     state, state_d;
    logic [4:0] cnt, cnt_d;
    logic [3:0] hold, hold_d;
    logic       pb_d;
    logic       busy_d;
    logic [7:0] presses_d;
    logic [7:0] lfsr;
    logic       unused_lfsr_hi;

    assign unused_lfsr_hi = ^lfsr[7:3];

    tow_lfsr8 #(
        .SEED (SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            hold    <= '0;
            pb      <= 1'b0;
            busy    <= 1'b0;
            presses <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            hold    <= hold_d;
            pb      <= pb_d;
            busy    <= busy_d;
            presses <= presses_d;
        end
    end

    // pb_d defaults low so only the PRESS path can raise the button
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        hold_d    = hold;
        pb_d      = 1'b0;
        presses_d = presses;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_d = ARM;
                end
                ARM: begin
                    if (leds_on) begin
                        state_d = REACT;
                        cnt_d   = react_delay(level, lfsr[2:0]);
                    end
                end
                REACT: begin
                    cnt_d = cnt - 5'd1;
                    if (!leds_on) begin
                        state_d = ARM;
                    end else if (cnt == 5'd1) begin
                        state_d   = PRESS;
                        pb_d      = 1'b1;
                        hold_d    = HOLD_LD;
                        presses_d = (presses == 8'hFF) ? presses
                                                       : presses + 8'd1;
                    end
                end
                PRESS: begin
                    if (hold == 4'd1) begin
                        state_d = WAIT_CLR;
                    end else begin
                        pb_d   = 1'b1;
                        hold_d = hold - 4'd1;
                    end
                end
                WAIT_CLR: begin
                    if (clr) begin
                        state_d = ARM;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_tow_cpu_player.sv
// Scoreboard bench for tow_cpu_player: stimulus pushes expected presses,
// a negedge monitor pops and checks each pb pulse as it appears.
module tb_tow_cpu_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       leds_on;
    logic       clr;
    logic [1:0] level;
    logic       pb;
    logic       busy;
    logic [7:0] presses;

    int         tests = 0;
    int         fails = 0;
    int         cyc;
    logic [7:0] ml;
    int         falls = 0;
    int         exp_presses = 0;

    typedef struct {
        int rise;
        int width;
        int pr;
    } exp_t;

    exp_t sb[$];

    tow_cpu_player #(
        .HOLD (2),
        .SEED (8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .leds_on (leds_on),
        .clr     (clr),
        .level   (level),
        .pb      (pb),
        .busy    (busy),
        .presses (presses)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic int base_of(input logic [1:0] lv);
        case (lv)
            2'd0: return 12;
            2'd1: return 8;
            2'd2: return 4;
            default: return 1;
        endcase
    endfunction

    // Edge counter and reference LFSR, both cleared by reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc <= 0;
            ml  <= 8'hA5;
        end else begin
            cyc <= cyc + 1;
            ml  <= lfsr_next(ml);
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // k = edges from now until ARM samples the light
    task automatic push_exp(input int k, input int width);
        logic [7:0] l;
        exp_t       e;
        l = ml;
        for (int i = 1; i < k; i++) l = lfsr_next(l);
        exp_presses = (exp_presses >= 255) ? 255 : exp_presses + 1;
        e.rise  = cyc + k + base_of(level) + int'(l[2:0]);
        e.width = width;
        e.pr    = exp_presses;
        sb.push_back(e);
    endtask

    logic pb_prev = 1'b0;
    int   width_cnt = 0;
    bit   have = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (pb && !pb_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                have = 1'b0;
                $display("FAIL unexpected_press: pb rose at cycle %0d, none queued", cyc);
            end else begin
                cur  = sb.pop_front();
                have = 1'b1;
                chk("rise_cycle", cyc, cur.rise);
                chk("presses_at_rise", int'(presses), cur.pr);
            end
            width_cnt = 1;
        end else if (pb) begin
            width_cnt++;
        end else if (pb_prev) begin
            if (have) chk("pulse_width", width_cnt, cur.width);
            have = 1'b0;
            falls++;
        end
        pb_prev = pb;
    end

    task automatic wait_fall(input int f0, input string name);
        int n;
        n = 0;
        while (falls == f0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pulse_done"}, int'(falls != f0), 1);
    endtask

    task automatic wait_rise(input string name);
        int n;
        n = 0;
        while (!pb && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_rise_seen"}, int'(pb), 1);
    endtask

    task automatic do_clr_press(input int hold_n);
        int f0;
        f0 = falls;
        @(negedge clk);
        clr = 1'b1;
        push_exp(2, 2);
        repeat (hold_n) @(negedge clk);
        clr = 1'b0;
        wait_fall(f0, "clr_press");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        rst = 1'b0; en = 1'b0; leds_on = 1'b0; clr = 1'b0; level = 2'd3;
        repeat (2) @(negedge clk);
        chk("reset_pb", int'(pb), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_presses", int'(presses), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // nominal press, then no re-press without clr
        f0 = falls;
        en = 1'b1;
        leds_on = 1'b1;
        push_exp(2, 2);
        @(negedge clk);
        chk("busy_rise", int'(busy), 1);
        wait_fall(f0, "nominal");
        repeat (6) @(negedge clk);
        chk("nominal_presses", int'(presses), exp_presses);
        chk("wait_clr_busy", int'(busy), 1);

        // clr held 4 cycles: exactly one re-arm
        do_clr_press(4);
        repeat (6) @(negedge clk);
        chk("clr_hold_presses", int'(presses), exp_presses);

        // clr during PRESS is ignored
        f0 = falls;
        @(negedge clk);
        clr = 1'b1;
        push_exp(2, 2);
        @(negedge clk);
        clr = 1'b0;
        wait_rise("clr_in_press");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_fall(f0, "clr_in_press");
        repeat (6) @(negedge clk);
        chk("clr_in_press_presses", int'(presses), exp_presses);

        // light drop during REACT at slowest level
        @(negedge clk);
        level = 2'd0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        leds_on = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_presses", int'(presses), exp_presses);
        chk("drop_busy", int'(busy), 1);
        f0 = falls;
        leds_on = 1'b1;
        push_exp(1, 2);
        wait_fall(f0, "relight");

        // disable on first PRESS cycle truncates the pulse
        level = 2'd3;
        @(negedge clk);
        clr = 1'b1;
        push_exp(2, 1);
        @(negedge clk);
        clr = 1'b0;
        wait_rise("disable");
        en = 1'b0;
        @(negedge clk);
        chk("disable_pb", int'(pb), 0);
        chk("disable_busy", int'(busy), 0);
        chk("disable_presses", int'(presses), exp_presses);
        repeat (2) @(negedge clk);
        chk("disable_idle_busy", int'(busy), 0);

        // asynchronous reset in the middle of a press
        @(negedge clk);
        en = 1'b1;
        push_exp(2, 1);
        wait_rise("reset_mid");
        rst = 1'b0;
        #1;
        chk("async_rst_pb", int'(pb), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_presses", int'(presses), 0);
        exp_presses = 0;
        @(negedge clk);
        chk("rst_lfsr_seed", int'(dut.lfsr), 8'hA5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_lfsr_seed", int'(dut.lfsr), 8'hA5);
        f0 = falls;
        push_exp(2, 2);
        wait_fall(f0, "post_reset");
        chk("post_reset_presses", int'(presses), 1);

        // saturation of the press counter
        for (int i = 0; i < 300; i++) do_clr_press(1);
        repeat (4) @(negedge clk);
        chk("sat_presses", int'(presses), 255);
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
